// File: rtl/regfile_pkg.sv
// Shared constants, address type and popcount helper for the multi-port register file.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef ZERO_WORD
`define ZERO_WORD {`DATA_WIDTH{1'b0}}
`endif

package regfile_pkg;
    localparam int DEF_DATA_WIDTH = `DATA_WIDTH;
    localparam int DEF_NUM_REGS   = 32;
    localparam logic [DEF_DATA_WIDTH-1:0] ZERO_WORD = `ZERO_WORD;
    // Widest busy vector popcount handles; NUM_REGS must not exceed it.
    localparam int POP_MAX = 256;

    typedef logic [$clog2(DEF_NUM_REGS)-1:0] reg_addr_t;

    function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX; i++) n += 32'(v[i]);
        return n;
    endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// Request/response bundle between the issue/writeback stages and the register file.
// No handshake: every enabled write, read and alloc is accepted in the cycle it is presented.
interface regfile_mp_if #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 32,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_WR-1:0]                 w_ena;
    logic [NUM_WR-1:0][AW-1:0]         w_addr;
    logic [NUM_WR-1:0][DATA_WIDTH-1:0] w_data;
    logic [NUM_RD-1:0]                 r_ena;
    logic [NUM_RD-1:0][AW-1:0]         r_addr;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0] r_data;
    logic [NUM_RD-1:0]                 r_busy;
    logic                              alloc_ena;
    logic [AW-1:0]                     alloc_addr;
    logic                              flush;
    logic [AW:0]                       busy_cnt;

    modport master (
        output w_ena, w_addr, w_data, r_ena, r_addr, alloc_ena, alloc_addr, flush,
        input  r_data, r_busy, busy_cnt
    );

    modport slave (
        input  w_ena, w_addr, w_data, r_ena, r_addr, alloc_ena, alloc_addr, flush,
        output r_data, r_busy, busy_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: alloc sets, writeback clears, flush clears all; drives r_busy and busy_cnt.
module regfile_scoreboard import regfile_pkg::*; #(
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_WR-1:0]         w_ena,
    input  logic [NUM_WR-1:0][AW-1:0] w_addr,
    input  logic [NUM_RD-1:0]         r_ena,
    input  logic [NUM_RD-1:0][AW-1:0] r_addr,
    input  logic                      alloc_ena,
    input  logic [AW-1:0]             alloc_addr,
    input  logic                      flush,
    output logic [NUM_RD-1:0]         r_busy,
    output logic [AW:0]               busy_cnt
);
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;

    // Alloc is applied after the write clears so a newer producer keeps ownership.
    always_comb begin
        busy_nxt = busy;
        for (int j = 0; j < NUM_WR; j++)
            if (w_ena[j]) busy_nxt[w_addr[j]] = 1'b0;
        if (flush) busy_nxt = '0;
        else if (alloc_ena && alloc_addr != '0) busy_nxt[alloc_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= (AW+1)'(popcount(POP_MAX'(busy_nxt)));
        end
    end

    always_comb begin
        r_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (r_ena[i] && r_addr[i] != '0) begin
                r_busy[i] = busy[r_addr[i]];
                for (int j = 0; j < NUM_WR; j++)
                    if (w_ena[j] && w_addr[j] == r_addr[i]) r_busy[i] = 1'b0;
            end
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass and a busy scoreboard; x0 is hardwired zero.
module regfile_mp import regfile_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Later ports are assigned last, so the highest-index port wins an address conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++)
                if (bus.w_ena[j] && bus.w_addr[j] != '0)
                    regs[bus.w_addr[j]] <= bus.w_data[j];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            bus.r_data[i] = DATA_WIDTH'(ZERO_WORD);
            if (bus.r_ena[i] && bus.r_addr[i] != '0) begin
                bus.r_data[i] = regs[bus.r_addr[i]];
                for (int j = 0; j < NUM_WR; j++)
                    if (bus.w_ena[j] && bus.w_addr[j] == bus.r_addr[i])
                        bus.r_data[i] = bus.w_data[j];
            end
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .w_ena      (bus.w_ena),
        .w_addr     (bus.w_addr),
        .r_ena      (bus.r_ena),
        .r_addr     (bus.r_addr),
        .alloc_ena  (bus.alloc_ena),
        .alloc_addr (bus.alloc_addr),
        .flush      (bus.flush),
        .r_busy     (bus.r_busy),
        .busy_cnt   (bus.busy_cnt)
    );
endmodule
